// File: rtl/scramble_sequencer.sv
// Scramble move generator for the cube driver.
// Emits a bounded run of pseudo-random moves (face 0..5, quarter turns 1/2/3) over a
// valid/ready handshake. It never repeats a face back to back, and it ends each completed
// run with a one-cycle done pulse.
module scramble_sequencer #(
    parameter int unsigned NUM_MOVES = 20,
    parameter int unsigned CNT_W     = 6,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             ready,
    output logic             move_valid,
    output logic [2:0]       move_face,
    output logic [2:0]       move_rot,
    output logic [CNT_W-1:0] move_index,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        StIdle,
        StGen,
        StOffer,
        StFinish
    } state_e;

    localparam logic [15:0]      LfsrMask = 16'hB400;
    localparam logic [CNT_W-1:0] LastIdx  = CNT_W'(NUM_MOVES);
    localparam logic [2:0]       NoFace   = 3'd7;

    state_e           state_q, state_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [2:0]       prev_face_q, prev_face_d;
    logic [2:0]       face_q, face_d;
    logic [2:0]       rot_q, rot_d;
    logic [CNT_W-1:0] index_q, index_d;

    logic [15:0]      lfsr_shift;
    logic [2:0]       face_c;
    logic [2:0]       rot_c;
    logic             face_ok;
    logic [CNT_W-1:0] index_inc;

    // Galois right shift; the zero state cannot be left by shifting, so reload the seed
    assign lfsr_shift = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrMask : 16'h0000);

    // Next LFSR value, computed every cycle regardless of FSM state
    always_comb begin
        lfsr_d = lfsr_shift;
        if (lfsr_q == 16'h0000) begin
            lfsr_d = LFSR_SEED;
        end
    end

    assign face_c  = lfsr_q[2:0];
    assign face_ok = (face_c < 3'd6) && (face_c != prev_face_q);

    // Map two LFSR bits onto a quarter-turn count; 11 folds onto CW
    always_comb begin
        rot_c = 3'd1;
        unique case (lfsr_q[4:3])
            2'b00:   rot_c = 3'd1;
            2'b01:   rot_c = 3'd3;
            2'b10:   rot_c = 3'd2;
            2'b11:   rot_c = 3'd1;
            default: rot_c = 3'd1;
        endcase
    end

    // Saturate so the counter can never wrap inside a run
    assign index_inc = (index_q < LastIdx) ? index_q + CNT_W'(1) : index_q;

    // Next-state and datapath update; abort overrides every transition out of IDLE
    always_comb begin
        state_d     = state_q;
        prev_face_d = prev_face_q;
        face_d      = face_q;
        rot_d       = rot_q;
        index_d     = index_q;

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    index_d     = '0;
                    prev_face_d = NoFace;
                    state_d     = StGen;
                end
            end
            StGen: begin
                if (abort) begin
                    prev_face_d = NoFace;
                    state_d     = StIdle;
                end else if (face_ok) begin
                    face_d  = face_c;
                    rot_d   = rot_c;
                    state_d = StOffer;
                end
            end
            StOffer: begin
                if (abort) begin
                    prev_face_d = NoFace;
                    state_d     = StIdle;
                end else if (ready) begin
                    index_d     = index_inc;
                    prev_face_d = face_q;
                    state_d     = (index_inc == LastIdx) ? StFinish : StGen;
                end
            end
            StFinish: begin
                if (abort) begin
                    prev_face_d = NoFace;
                end
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            lfsr_q      <= LFSR_SEED;
            prev_face_q <= NoFace;
            face_q      <= 3'd0;
            rot_q       <= 3'd0;
            index_q     <= '0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            prev_face_q <= prev_face_d;
            face_q      <= face_d;
            rot_q       <= rot_d;
            index_q     <= index_d;
        end
    end

    assign move_valid = (state_q == StOffer);
    assign move_face  = face_q;
    assign move_rot   = rot_q;
    assign move_index = index_q;
    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StFinish);

endmodule

// File: tb/tb_scramble_sequencer.sv
// Bench for scramble_sequencer: a reference LFSR plus a move scoreboard that predicts every
// offered move and its exact presentation cycle.
module tb_scramble_sequencer;

    localparam int unsigned NUM_MOVES = 20;
    localparam int unsigned CNT_W     = 6;
    localparam logic [15:0] SEED      = 16'hACE1;

    typedef struct {
        logic [2:0] face;
        logic [2:0] rot;
        int         cyc;
    } exp_move_t;

    logic             clk   = 1'b0;
    logic             rst   = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             ready = 1'b0;
    logic             move_valid;
    logic [2:0]       move_face;
    logic [2:0]       move_rot;
    logic [CNT_W-1:0] move_index;
    logic             busy;
    logic             done;

    scramble_sequencer #(
        .NUM_MOVES(NUM_MOVES),
        .CNT_W    (CNT_W),
        .LFSR_SEED(SEED)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .ready     (ready),
        .move_valid(move_valid),
        .move_face (move_face),
        .move_rot  (move_rot),
        .move_index(move_index),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        if (v == 16'h0000) return SEED;
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    function automatic logic [2:0] rot_of(input logic [1:0] b);
        case (b)
            2'b01:   return 3'd3;
            2'b10:   return 3'd2;
            default: return 3'd1;
        endcase
    endfunction

    // First acceptable candidate starting from the lfsr value seen in the first GEN cycle
    function automatic exp_move_t predict(input logic [15:0] first_lfsr, input logic [2:0] prev,
                                          input int gen_cyc);
        logic [15:0] v;
        exp_move_t   m;
        v = first_lfsr;
        for (int k = 0; k < 1000; k++) begin
            if (v[2:0] < 3'd6 && v[2:0] != prev) begin
                m.face = v[2:0];
                m.rot  = rot_of(v[4:3]);
                m.cyc  = gen_cyc + k + 1;
                return m;
            end
            v = lfsr_step(v);
        end
        m.face = 3'd7;
        m.rot  = 3'd0;
        m.cyc  = -1;
        return m;
    endfunction

    // Reference LFSR, stepping every cycle like the design's
    logic [15:0] m_lfsr;
    always @(posedge clk or negedge rst) begin
        if (!rst) m_lfsr <= SEED;
        else      m_lfsr <= lfsr_step(m_lfsr);
    end

    exp_move_t  sb_q[$];
    exp_move_t  cur;
    logic [5:0] run_log[$];
    logic [5:0] first_seq[$];
    int         cyc          = 0;
    int         m_index      = 0;
    logic [2:0] m_prev       = 3'd7;
    bit         offer_seen   = 1'b0;
    int         exp_done_cyc = -1;
    int         hs_count     = 0;
    int         done_count   = 0;

    // Monitor on the falling edge: all inputs and outputs for this cycle are settled
    always @(negedge clk) begin
        if (!rst) begin
            sb_q.delete();
            offer_seen   = 1'b0;
            m_index      = 0;
            m_prev       = 3'd7;
            exp_done_cyc = -1;
        end else begin
            if (done || cyc == exp_done_cyc)
                check_eq("done_pulse", 32'(done), 32'(cyc == exp_done_cyc));
            if (done) done_count++;
            if (move_valid && !offer_seen) begin
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_offer", 32'(1), 32'(0));
                end else begin
                    cur = sb_q.pop_front();
                    check_eq("face", 32'(move_face), 32'(cur.face));
                    check_eq("rot", 32'(move_rot), 32'(cur.rot));
                    check_eq("offer_cycle", cyc, cur.cyc);
                end
                offer_seen = 1'b1;
            end
            if (abort && busy) begin
                sb_q.delete();
                offer_seen   = 1'b0;
                m_prev       = 3'd7;
                exp_done_cyc = -1;
            end else if (!abort && !busy && start) begin
                m_index = 0;
                m_prev  = 3'd7;
                sb_q.push_back(predict(lfsr_step(m_lfsr), 3'd7, cyc + 1));
            end else if (move_valid && ready) begin
                check_eq("index_at_hs", 32'(move_index), m_index);
                check_eq("no_repeat", 32'(move_face == m_prev), 32'(0));
                run_log.push_back({move_face, move_rot});
                hs_count++;
                m_index++;
                m_prev     = move_face;
                offer_seen = 1'b0;
                if (m_index == NUM_MOVES) exp_done_cyc = cyc + 1;
                else sb_q.push_back(predict(lfsr_step(m_lfsr), move_face, cyc + 1));
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_stats();
        run_log.delete();
        hs_count   = 0;
        done_count = 0;
    endtask

    task automatic wait_idle(input int max, input string tag);
        int n;
        n = 0;
        while (busy && n < max) begin
            tick();
            n++;
        end
        if (busy) check_eq({tag, "_timeout"}, 32'(1), 32'(0));
    endtask

    task automatic check_full_run(input string tag);
        check_eq({tag, "_handshakes"}, hs_count, NUM_MOVES);
        check_eq({tag, "_done_count"}, done_count, 1);
        check_eq({tag, "_index"}, 32'(move_index), NUM_MOVES);
        check_eq({tag, "_busy"}, 32'(busy), 32'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "time limit");
    end

    initial begin
        int n;
        int bad;

        // Power-on reset
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        check_eq("rst_busy", 32'(busy), 32'(0));
        check_eq("rst_valid", 32'(move_valid), 32'(0));
        check_eq("rst_done", 32'(done), 32'(0));
        check_eq("rst_index", 32'(move_index), 32'(0));
        check_eq("rst_face", 32'(move_face), 32'(0));
        check_eq("rst_rot", 32'(move_rot), 32'(0));

        // Full run, ready tied high
        repeat (3) tick();
        clear_stats();
        ready = 1'b1;
        pulse_start();
        wait_idle(2000, "run1");
        check_full_run("run1");
        first_seq = run_log;

        // Back-pressure: hold the first offer for 50 cycles
        tick();
        clear_stats();
        ready = 1'b0;
        pulse_start();
        n = 0;
        while (!move_valid && n < 200) begin
            tick();
            n++;
        end
        check_eq("hold_first_valid", 32'(move_valid), 32'(1));
        bad = 0;
        repeat (50) begin
            tick();
            if (!move_valid || move_face !== cur.face || move_rot !== cur.rot || move_index != 0)
                bad++;
        end
        check_eq("hold_stable_cycles", bad, 0);
        ready = 1'b1;
        tick();
        check_eq("hold_index_after", 32'(move_index), 32'(1));
        n = 0;
        while (busy && n < 4000) begin
            ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        ready = 1'b1;
        wait_idle(10, "bp");
        check_full_run("bp");

        // Abort during the 7th offer
        tick();
        clear_stats();
        pulse_start();
        n = 0;
        while (!(move_valid && move_index == 6) && n < 2000) begin
            tick();
            n++;
        end
        check_eq("abort_reach_7th", 32'(move_valid && move_index == 6), 32'(1));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("abort_busy", 32'(busy), 32'(0));
        check_eq("abort_valid", 32'(move_valid), 32'(0));
        check_eq("abort_index", 32'(move_index), 32'(6));
        repeat (5) tick();
        check_eq("abort_no_done", done_count, 0);
        check_eq("abort_handshakes", hs_count, 6);

        // Abort together with start in IDLE
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check_eq("abort_start_idle", 32'(busy), 32'(0));

        // Full run after abort
        clear_stats();
        pulse_start();
        wait_idle(2000, "post_abort");
        check_full_run("post_abort");

        // Start re-pulsed mid-run is ignored
        tick();
        clear_stats();
        pulse_start();
        n = 0;
        while (move_index != 5 && n < 2000) begin
            tick();
            n++;
        end
        pulse_start();
        wait_idle(2000, "restart");
        check_full_run("restart");
        repeat (3) tick();
        check_eq("restart_single_done", done_count, 1);

        // Asynchronous reset in GEN, then replay the power-on run
        clear_stats();
        pulse_start();
        n = 0;
        while (!(busy && !move_valid && move_index >= 2) && n < 2000) begin
            tick();
            n++;
        end
        check_eq("areset_in_gen", 32'(busy && !move_valid), 32'(1));
        #2;
        rst = 1'b0;
        #1;
        check_eq("areset_busy", 32'(busy), 32'(0));
        check_eq("areset_valid", 32'(move_valid), 32'(0));
        check_eq("areset_index", 32'(move_index), 32'(0));
        check_eq("areset_face", 32'(move_face), 32'(0));
        check_eq("areset_rot", 32'(move_rot), 32'(0));
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) tick();
        clear_stats();
        ready = 1'b1;
        pulse_start();
        wait_idle(2000, "replay");
        check_full_run("replay");
        check_eq("replay_len", run_log.size(), first_seq.size());
        for (int i = 0; i < run_log.size() && i < first_seq.size(); i++)
            check_eq($sformatf("replay_move%0d", i), 32'(run_log[i]), 32'(first_seq[i]));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
